// File: rtl/swap_counter_pkg.sv
// Shared types for the swap/counter monitor: decoded operation, FSM state and
// statistics width, plus the saturating increment used by the event counters.
package swap_counter_pkg;

  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    COUNT   = 2'd1,
    SWAP    = 2'd2,
    ILLEGAL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/swap_counter_monitor_if.sv
// Sample/decode bus of the swap/counter monitor. Statistics outputs exist only
// when MONITOR_STATS_EN is defined. The bus carries no backpressure: a
// snapshot is taken on every cycle with sample_valid=1, and op_valid is a
// one-cycle pulse with no ready.
interface swap_counter_monitor_if
  import swap_counter_pkg::*;
#(
  parameter int W = 4
);
  logic           sample_valid;
  logic [W-1:0]   up_in;
  logic [W-1:0]   down_in;
  logic           clear_err;
  op_t            op_out;
  logic           op_valid;
  logic           ambiguous;
  logic           err;
  state_t         state_dbg;
`ifdef MONITOR_STATS_EN
  logic [STAT_W-1:0] count_events;
  logic [STAT_W-1:0] swap_events;
  logic [STAT_W-1:0] illegal_events;
`endif

  modport master (
`ifdef MONITOR_STATS_EN
    input  count_events, swap_events, illegal_events,
`endif
    output sample_valid, up_in, down_in, clear_err,
    input  op_out, op_valid, ambiguous, err, state_dbg
  );

  modport slave (
`ifdef MONITOR_STATS_EN
    output count_events, swap_events, illegal_events,
`endif
    input  sample_valid, up_in, down_in, clear_err,
    output op_out, op_valid, ambiguous, err, state_dbg
  );

endinterface

// File: rtl/swap_counter_monitor_pair_classify.sv
// Combinational classifier: explains the step (U,D) -> (U',D') as HOLD, COUNT
// or SWAP with HOLD > COUNT > SWAP priority, flagging multiple matches.
module pair_classify
  import swap_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] u_new_i,
  input  logic [W-1:0] d_new_i,
  output op_t          op_o,
  output logic         ambiguous_o
);

  logic hold_m;
  logic count_m;
  logic swap_m;

  // Arithmetic stays W bits wide so 15->0 and 0->15 wrap naturally.
  assign hold_m  = (u_new_i == u_i) && (d_new_i == d_i);
  assign count_m = (u_new_i == u_i + W'(1)) && (d_new_i == d_i - W'(1));
  assign swap_m  = (u_new_i == d_i) && (d_new_i == u_i);

  assign ambiguous_o = (hold_m & count_m) | (hold_m & swap_m) | (count_m & swap_m);

  always_comb begin
    op_o = ILLEGAL;
    if (hold_m)       op_o = HOLD;
    else if (count_m) op_o = COUNT;
    else if (swap_m)  op_o = SWAP;
  end

endmodule

// File: rtl/swap_counter_monitor.sv
// Swap/counter monitor: tracks (up,down) snapshots and reports the operation
// explaining each step one cycle later. Optional event statistics: MONITOR_STATS_EN.
module swap_counter_monitor
  import swap_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  swap_counter_monitor_if.slave  bus
);

  state_t         state_q, state_d;
  logic [W-1:0]   u_q, u_d;
  logic [W-1:0]   d_q, d_d;
  op_t            op_q, op_d;
  logic           op_valid_q, op_valid_d;
  logic           amb_q, amb_d;
  op_t            cls_op;
  logic           cls_amb;

  pair_classify #(.W(W)) u_classify (
    .u_i         (u_q),
    .d_i         (d_q),
    .u_new_i     (bus.up_in),
    .d_new_i     (bus.down_in),
    .op_o        (cls_op),
    .ambiguous_o (cls_amb)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      u_q        <= '0;
      d_q        <= '0;
      op_q       <= HOLD;
      op_valid_q <= 1'b0;
      amb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      d_q        <= d_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      amb_q      <= amb_d;
    end
  end

  // Every valid sample refreshes the reference; only TRACK decodes it.
  always_comb begin
    state_d    = state_q;
    u_d        = u_q;
    d_d        = d_q;
    op_d       = op_q;
    op_valid_d = 1'b0;
    amb_d      = 1'b0;
    if (bus.sample_valid) begin
      u_d = bus.up_in;
      d_d = bus.down_in;
    end
    unique case (state_q)
      EMPTY: begin
        if (bus.sample_valid) state_d = TRACK;
      end
      TRACK: begin
        if (bus.sample_valid) begin
          op_d       = cls_op;
          op_valid_d = 1'b1;
          amb_d      = cls_amb;
          if (cls_op == ILLEGAL) state_d = ERROR;
        end
      end
      ERROR: begin
        if (bus.clear_err) state_d = TRACK;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bus.op_out    = op_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.ambiguous = amb_q;
  assign bus.err       = (state_q == ERROR);
  assign bus.state_dbg = state_q;

`ifdef MONITOR_STATS_EN
  logic [STAT_W-1:0] count_ev_q;
  logic [STAT_W-1:0] swap_ev_q;
  logic [STAT_W-1:0] illegal_ev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_ev_q   <= '0;
      swap_ev_q    <= '0;
      illegal_ev_q <= '0;
    end else if (op_valid_d) begin
      if (op_d == COUNT)   count_ev_q   <= sat_inc(count_ev_q);
      if (op_d == SWAP)    swap_ev_q    <= sat_inc(swap_ev_q);
      if (op_d == ILLEGAL) illegal_ev_q <= sat_inc(illegal_ev_q);
    end
  end

  assign bus.count_events   = count_ev_q;
  assign bus.swap_events    = swap_ev_q;
  assign bus.illegal_events = illegal_ev_q;
`endif

endmodule

// File: tb/tb_swap_counter_monitor.sv
// Directed bench for swap_counter_monitor; statistics checks are compiled in
// when MONITOR_STATS_EN is defined.
module tb_swap_counter_monitor;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  swap_counter_monitor_if #(.W(4)) bus ();

  swap_counter_monitor #(.W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.clear_err    = 1'b0;
    bus.up_in        = '0;
    bus.down_in      = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One-cycle sample; returns at the next falling edge, where the registered
  // result of that sample is visible.
  task automatic drive_sample(input logic [3:0] u, input logic [3:0] d, input logic clr);
    @(negedge clock);
    bus.sample_valid = 1'b1;
    bus.up_in        = u;
    bus.down_in      = d;
    bus.clear_err    = clr;
    @(negedge clock);
    bus.sample_valid = 1'b0;
    bus.clear_err    = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [1:0] op, input logic amb);
    check({tag, "_valid"}, 32'(bus.op_valid), 32'd1);
    check({tag, "_op"}, 32'(bus.op_out), 32'(op));
    check({tag, "_amb"}, 32'(bus.ambiguous), 32'(amb));
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.clear_err    = 1'b0;
    bus.up_in        = '0;
    bus.down_in      = '0;
    repeat (2) @(negedge clock);
    check("rst_op", 32'(bus.op_out), 32'd0);
    check("rst_valid", 32'(bus.op_valid), 32'd0);
    check("rst_amb", 32'(bus.ambiguous), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    reset_n = 1'b1;

    // plain COUNT, one-cycle pulse
    drive_sample(4'd3, 4'd12, 1'b0);
    check("seed_valid", 32'(bus.op_valid), 32'd0);
    check("seed_state", 32'(bus.state_dbg), 32'd1);
    drive_sample(4'd4, 4'd11, 1'b0);
    expect_op("count", 2'd1, 1'b0);
    @(negedge clock);
    check("pulse_end", 32'(bus.op_valid), 32'd0);

    // wrap-around COUNT (also matches SWAP), then pure SWAP
    do_reset();
    drive_sample(4'd15, 4'd0, 1'b0);
    drive_sample(4'd0, 4'd15, 1'b0);
    expect_op("wrap", 2'd1, 1'b1);
    drive_sample(4'd15, 4'd0, 1'b0);
    expect_op("swap", 2'd2, 1'b0);

    // ambiguity cases and a clean HOLD; clear_err ignored in TRACK
    do_reset();
    drive_sample(4'd5, 4'd5, 1'b0);
    drive_sample(4'd5, 4'd5, 1'b0);
    expect_op("hold_amb", 2'd0, 1'b1);
    do_reset();
    drive_sample(4'd2, 4'd3, 1'b0);
    drive_sample(4'd3, 4'd2, 1'b0);
    expect_op("count_amb", 2'd1, 1'b1);
    drive_sample(4'd3, 4'd2, 1'b1);
    expect_op("hold", 2'd0, 1'b0);
    check("clr_track_state", 32'(bus.state_dbg), 32'd1);

    // ILLEGAL -> ERROR, tracking without decode, clear with snapshot
    do_reset();
    drive_sample(4'd1, 4'd1, 1'b0);
    drive_sample(4'd7, 4'd9, 1'b0);
    expect_op("illegal", 2'd3, 1'b0);
    check("illegal_err", 32'(bus.err), 32'd1);
    check("illegal_state", 32'(bus.state_dbg), 32'd2);
    drive_sample(4'd4, 4'd4, 1'b0);
    check("err_nodecode", 32'(bus.op_valid), 32'd0);
    check("err_hold", 32'(bus.err), 32'd1);
    drive_sample(4'd8, 4'd8, 1'b1);
    check("clr_nodecode", 32'(bus.op_valid), 32'd0);
    check("clr_err", 32'(bus.err), 32'd0);
    check("clr_state", 32'(bus.state_dbg), 32'd1);
    drive_sample(4'd9, 4'd7, 1'b0);
    expect_op("after_clr", 2'd1, 1'b0);
    check("after_clr_err", 32'(bus.err), 32'd0);

    // asynchronous reset mid-stream while ERROR and op_valid are high
    drive_sample(4'd0, 4'd0, 1'b0);
    expect_op("illegal2", 2'd3, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("async_err", 32'(bus.err), 32'd0);
    check("async_state", 32'(bus.state_dbg), 32'd0);
    check("async_valid", 32'(bus.op_valid), 32'd0);
    check("async_op", 32'(bus.op_out), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive_sample(4'd2, 4'd2, 1'b0);
    check("post_rst_seed", 32'(bus.op_valid), 32'd0);
    drive_sample(4'd2, 4'd2, 1'b0);
    expect_op("post_rst_hold", 2'd0, 1'b1);

`ifdef MONITOR_STATS_EN
    do_reset();
    check("stat_rst", 32'(bus.count_events), 32'd0);
    drive_sample(4'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      drive_sample(4'(i), 4'(16 - (i % 16)), 1'b0);
    end
    check("stat_count", 32'(bus.count_events), 32'd255);
    check("stat_swap", 32'(bus.swap_events), 32'd0);
    check("stat_illegal", 32'(bus.illegal_events), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swap_counter_monitor.md
SWAP_COUNTER_MONITOR -- requirements
Module: swap_counter_monitor

Interface
REQ-001 SHALL have parameter W, default 4, meaning width of each observed counter value.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port sample_valid  input  1  up_in/down_in hold a new snapshot this cycle.
REQ-005 SHALL have port up_in  input  W  observed up-counter value.
REQ-006 SHALL have port down_in  input  W  observed down-counter value.
REQ-007 SHALL have port clear_err  input  1  leaves ERROR state.
REQ-008 SHALL have port op_out  output  2  decoded operation (HOLD=0, COUNT=1, SWAP=2, ILLEGAL=3).
REQ-009 SHALL have port op_valid  output  1  op_out valid, one-cycle pulse.
REQ-010 SHALL have port ambiguous  output  1  more than one operation explains the transition; qualified by op_valid.
REQ-011 SHALL have port err  output  1  high whenever FSM is in ERROR.

Function
REQ-012 SHALL implement FSM states EMPTY (no reference snapshot), TRACK, ERROR.
REQ-013 EMPTY + sample_valid SHALL store the snapshot, go to TRACK and not assert op_valid.
REQ-014 TRACK + sample_valid SHALL compare the new snapshot (U',D') with the stored one (U,D), register op_out/op_valid/ambiguous at the next edge (latency 1), and store the new snapshot.
REQ-015 HOLD SHALL be decoded when U'=U and D'=D.
REQ-016 COUNT SHALL be decoded when U'=U+1 and D'=D-1, mod 2^W (15->0 and 0->15 are legal).
REQ-017 SWAP SHALL be decoded when U'=D and D'=U.
REQ-018 Priority SHALL be HOLD > COUNT > SWAP; ambiguous=1 when two or more match (e.g. U=D for HOLD/SWAP; D=U+1 for COUNT/SWAP).
REQ-019 No match SHALL give op_out=ILLEGAL, op_valid=1, and transition TRACK->ERROR.
REQ-020 ERROR SHALL keep tracking snapshots without decoding (op_valid=0) until clear_err=1, then go to TRACK using the latest snapshot.
REQ-021 clear_err and sample_valid in the same cycle in ERROR: the snapshot SHALL be stored, then go to TRACK, with no decode.
REQ-022 clear_err SHALL be ignored in EMPTY and TRACK.
REQ-023 sample_valid=0 SHALL leave the snapshot and state unchanged and give op_valid=0.

Reset
REQ-024 reset_n=0 SHALL immediately force state EMPTY, op_out=HOLD, op_valid=0, ambiguous=0, err=0, snapshot=0 and statistics=0, including mid-sequence.
REQ-025 The first sample after reset release SHALL only seed the snapshot.

Configuration
REQ-026 With MONITOR_STATS_EN defined, SHALL add outputs count_events, swap_events, illegal_events (8 bits each); each increments on its decode and saturates at 255.
REQ-027 Without MONITOR_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package swap_counter_pkg SHALL hold the op_t enum (HOLD, COUNT, SWAP, ILLEGAL), the state_t enum and the STAT_W=8 constant.
REQ-029 Combinational sub-module pair_classify SHALL take (U,D,U',D') and return op and ambiguous; the FSM and registers SHALL live in the top module.

Verification
REQ-030 Reset, then samples (3,12),(4,11) -> the second produces op=COUNT, op_valid pulse 1 cycle later, ambiguous=0.
REQ-031 Samples (15,0),(0,15) -> COUNT (wrap-around); then (15,0) -> SWAP.
REQ-032 Samples (5,5),(5,5) -> HOLD with ambiguous=1; (2,3),(3,2) -> COUNT with ambiguous=1.
REQ-033 Samples (1,1),(7,9) -> ILLEGAL, err=1; a further sample -> no op_valid; clear_err with (8,8), then (9,7) -> COUNT, err=0.
REQ-034 reset_n low mid-stream -> err=0 and state EMPTY at once; the next sample produces no op_valid.
REQ-035 With MONITOR_STATS_EN: 300 COUNT transitions -> count_events=255 (saturated), swap_events=0.
